// File: rtl/flo_pkg.sv
// flo_pkg
// Shared helpers and default configuration for the leading-one
// detector / normaliser pipeline (flo_norm_pipe).
//   clog2       : ceiling log2 for elaboration-time sizing
//   num_stages  : register stages for a tree of l levels cut every pe levels
//   L, S        : tree levels and register stages for the default N/PIPE_EVERY
//   flo_stage_t : stage register layout for the default widths
package flo_pkg;

  localparam int FLO_N          = 32;
  localparam int FLO_PIPE_EVERY = 2;
  localparam int FLO_EXP_W      = 8;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << r) < value) r = r + 1;
    end
    return r;
  endfunction

  function automatic int num_stages(input int l, input int pe);
    return (l + pe - 1) / pe;
  endfunction

  localparam int L = clog2(FLO_N);
  localparam int S = num_stages(L, FLO_PIPE_EVERY);

  typedef struct packed {
    logic                 valid;
    logic [FLO_N-1:0]     word;
    logic [L:0]           cnt;
    logic [FLO_EXP_W-1:0] exp;
  } flo_stage_t;

endpackage

// File: rtl/flo_norm_level.sv
// flo_norm_level
// One combinational level of the normalising shift tree. Level K inspects
// the top N>>(K+1) bits of the working word; if they are all zero the word
// is shifted left by that amount and count bit (L-1-K) is set.
// Ports:
//   word_i / word_o : working word in / out (N bits)
//   cnt_i  / cnt_o  : partial leading-zero count in / out (L+1 bits)
module flo_norm_level #(
  parameter int N = 32,
  parameter int L = 5,
  parameter int K = 0
) (
  input  logic [N-1:0] word_i,
  input  logic [L:0]   cnt_i,
  output logic [N-1:0] word_o,
  output logic [L:0]   cnt_o
);

  localparam int SH = N >> (K + 1);

  always_comb begin
    word_o = word_i;
    cnt_o  = cnt_i;
    if (word_i[N-1 -: SH] == '0) begin
      word_o          = word_i << SH;
      cnt_o[L-1-K]    = 1'b1;
    end
  end

endmodule

// File: rtl/flo_norm_pipe.sv
// flo_norm_pipe
// Pipelined leading-one detector and normaliser. An N-bit unsigned magnitude
// passes through a log2(N)-level shift tree, registered every PIPE_EVERY
// levels, with valid/ready flow control and per-stage bubble collapsing.
// Optional build macro FLO_EXP_ADJ_EN: carries exp_i with each beat and
// produces exp_o = exp_i - cnt_o, clamped to 0 with unf_o on underflow.
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid / in_ready  : input handshake, data_i sampled on transfer
//   data_i               : magnitude to normalise
//   exp_i                : input exponent (FLO_EXP_ADJ_EN)
//   out_valid / out_ready: output handshake
//   cnt_o                : leading-zero count 0..N
//   norm_o               : magnitude shifted so its MSB is 1 (0 for zero input)
//   zero_o               : input was zero
//   exp_o, unf_o         : adjusted exponent, underflow (FLO_EXP_ADJ_EN)
module flo_norm_pipe
  import flo_pkg::*;
#(
  parameter int N          = FLO_N,
  parameter int PIPE_EVERY = FLO_PIPE_EVERY,
  parameter int EXP_W      = FLO_EXP_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N-1:0]       data_i,
`ifdef FLO_EXP_ADJ_EN
  input  logic [EXP_W-1:0]   exp_i,
  output logic [EXP_W-1:0]   exp_o,
  output logic               unf_o,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [clog2(N):0]  cnt_o,
  output logic [N-1:0]       norm_o,
  output logic               zero_o
);

  localparam int NL = clog2(N);
  localparam int NS = num_stages(NL, PIPE_EVERY);

  // exp/unf stay constant zero when the exponent feature is not built and
  // are trimmed away by synthesis.
  typedef struct packed {
    logic             valid;
    logic [N-1:0]     word;
    logic [NL:0]      cnt;
    logic             zero;
    logic [EXP_W-1:0] exp;
    logic             unf;
  } stage_t;

  stage_t       st    [NS];
  logic [NS:0]  rdy;
  logic [N-1:0] w_in  [NL];
  logic [N-1:0] w_out [NL];
  logic [NL:0]  c_in  [NL];
  logic [NL:0]  c_out [NL];

  // Shift tree; a level starting a new stage reads the previous stage register.
  for (genvar k = 0; k < NL; k++) begin : g_lvl
    if (k == 0) begin : g_src_in
      assign w_in[k] = data_i;
      assign c_in[k] = '0;
    end else if (k % PIPE_EVERY == 0) begin : g_src_reg
      assign w_in[k] = st[k/PIPE_EVERY-1].word;
      assign c_in[k] = st[k/PIPE_EVERY-1].cnt;
    end else begin : g_src_comb
      assign w_in[k] = w_out[k-1];
      assign c_in[k] = c_out[k-1];
    end

    flo_norm_level #(.N(N), .L(NL), .K(k)) u_level (
      .word_i (w_in[k]),
      .cnt_i  (c_in[k]),
      .word_o (w_out[k]),
      .cnt_o  (c_out[k])
    );
  end

  // Bubble-collapsing ready chain: an empty stage accepts regardless of downstream.
  assign rdy[NS]  = out_ready;
  assign in_ready = rdy[0];

  for (genvar j = 0; j < NS; j++) begin : g_stg
    localparam int LAST_LVL = (((j + 1) * PIPE_EVERY < NL) ? (j + 1) * PIPE_EVERY : NL) - 1;

    stage_t           q;
    stage_t           nxt;
    logic             v_in;
    logic [EXP_W-1:0] e_in;

    assign rdy[j] = ~q.valid | rdy[j+1];
    assign st[j]  = q;

    if (j == 0) begin : g_vin_port
      assign v_in = in_valid;
`ifdef FLO_EXP_ADJ_EN
      assign e_in = exp_i;
`else
      assign e_in = '0;
`endif
    end else begin : g_vin_prev
      assign v_in = st[j-1].valid;
      assign e_in = st[j-1].exp;
    end

    if (j == NS - 1) begin : g_final
      // Zero detection and exponent adjust happen before the output register
      // so the outputs come straight from flops.
      logic             msb;
`ifdef FLO_EXP_ADJ_EN
      logic [EXP_W:0]   diff;
      assign diff = {1'b0, e_in} - (EXP_W + 1)'(c_out[NL-1]);
`endif
      assign msb = w_out[NL-1][N-1];

      always_comb begin
        nxt       = '0;
        nxt.valid = v_in;
        nxt.zero  = ~msb;
        if (msb) begin
          nxt.word = w_out[NL-1];
          nxt.cnt  = c_out[NL-1];
`ifdef FLO_EXP_ADJ_EN
          if (diff[EXP_W]) begin
            nxt.unf = 1'b1;
          end else begin
            nxt.exp = diff[EXP_W-1:0];
          end
`endif
        end else begin
          nxt.cnt = (NL + 1)'(N);
        end
      end
    end else begin : g_mid
      always_comb begin
        nxt       = '0;
        nxt.valid = v_in;
        nxt.word  = w_out[LAST_LVL];
        nxt.cnt   = c_out[LAST_LVL];
        nxt.exp   = e_in;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        q <= '0;
      end else if (rdy[j]) begin
        if (v_in) begin
          q <= nxt;
        end else begin
          q.valid <= 1'b0;
        end
      end
    end
  end

  assign out_valid = st[NS-1].valid;
  assign cnt_o     = st[NS-1].cnt;
  assign norm_o    = st[NS-1].word;
  assign zero_o    = st[NS-1].zero;
`ifdef FLO_EXP_ADJ_EN
  assign exp_o     = st[NS-1].exp;
  assign unf_o     = st[NS-1].unf;
`endif

endmodule

// File: doc/flo_norm_pipe.md
Name: flo_norm_pipe

Overview:
- Pipelined, parametrised leading-one detector and normaliser for the dot-product datapath.
- Takes an N-bit unsigned magnitude and returns:
  - the leading-zero count;
  - the magnitude shifted left so its MSB is 1;
  - a zero flag.
- Uses a log2(N)-level shift tree, registered every PIPE_EVERY levels, with valid/ready flow control on both sides.
- Sits between the accumulator and the result packer.

Parameters:
- N, 32: data width; must be a power of 2, N >= 4.
- PIPE_EVERY, 2: tree levels per register stage; 1..log2(N).
- EXP_W, 8: exponent width; used only with FLO_EXP_ADJ_EN.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- data_i  in  N  magnitude to normalise.
- exp_i  in  EXP_W  input exponent (FLO_EXP_ADJ_EN only).
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- cnt_o  out  log2(N)+1  leading-zero count, 0..N.
- norm_o  out  N  normalised magnitude.
- zero_o  out  1  data_i was zero.
- exp_o  out  EXP_W  adjusted exponent (FLO_EXP_ADJ_EN only).
- unf_o  out  1  exponent underflow (FLO_EXP_ADJ_EN only).

Behaviour:
- Tree structure: L = log2(N) levels. Level k (k = 0..L-1) acts on the working word w:
  - if w[N-1 -: N>>(k+1)] == 0, then w <<= N>>(k+1) and count bit (L-1-k) = 1;
  - else both are unchanged.
- Zero input: after all levels, if w[N-1] == 0, then zero_o = 1, cnt_o = N, norm_o = 0. Otherwise zero_o = 0, cnt_o[L] = 0, norm_o = w.
- Pipelining: S = ceil(L/PIPE_EVERY) register stages. The last stage drives the outputs directly from registers. Latency from input handshake to out_valid is S cycles when there is no stall.
- Register contents: each stage holds valid, partial word, partial count, and exp if the feature is enabled.
- Flow control uses per-stage bubble collapsing:
  - stage i loads when !v[i] || ready[i+1];
  - ready[S] = out_ready;
  - in_ready = ready[0];
  - the ready chain is combinational.
- Throughput is one beat per cycle. Up to S beats can be in flight; no beat is ever dropped or duplicated.
- Handshake rules:
  - A transfer occurs when valid && ready are both high on a rising edge.
  - While out_valid && !out_ready, all outputs hold stable.
  - in_valid may deassert freely; data_i is sampled only on a transfer.
- Reset: rst_n low clears all stage valid bits and datapath registers to 0, asynchronously. During reset:
  - out_valid = 0, cnt_o = 0, norm_o = 0, zero_o = 0, exp_o = 0, unf_o = 0;
  - in_ready = 1.
  In-flight beats are discarded. The first transfer occurs on the first edge after release.
- Simultaneous accept-at-input and drain-at-output in a full pipe is allowed; occupancy is unchanged.

Optional Feature:
- Macro FLO_EXP_ADJ_EN.
- When defined:
  - exp_i travels with the beat;
  - exp_o = exp_i - cnt_o, computed in EXP_W+1 bits;
  - if the result is negative, exp_o = 0 and unf_o = 1;
  - a zero input gives exp_o = 0 and unf_o = 0.
  - Adds no latency; the subtract is in the last stage.
- When undefined: the exp_i, exp_o and unf_o ports and their registers are absent.

Decomposition:
- Package flo_pkg contains:
  - function clog2;
  - localparams L and S derived from N and PIPE_EVERY;
  - typedef flo_stage_t {valid, word, cnt, exp}.
- One sub-module, flo_norm_level: a combinational single tree level parametrised by level index k. It is instantiated L times in a generate loop; registers are inserted after every PIPE_EVERY levels.

Test Plan:
- N=32, PIPE_EVERY=2 (S=3), out_ready=1, data_i=0x00000001 -> 3 cycles later: cnt_o=31, norm_o=0x80000000, zero_o=0.
- data_i=0x80000000 then 0x00010000 back-to-back -> cnt_o=0 then 15 on consecutive cycles; norm_o=0x80000000 both times.
- data_i=0 -> cnt_o=32, norm_o=0, zero_o=1.
- Backpressure: 6 back-to-back beats with out_ready=0 for 5 cycles:
  - in_ready falls after 3 accepted beats;
  - outputs hold beat 1;
  - on release, all 6 beats emerge in order with no loss.
- rst_n pulsed low with 2 beats in flight -> out_valid=0 immediately, in_ready=1, and no stale beat appears after release.
- FLO_EXP_ADJ_EN:
  - exp_i=3, data_i=0x00000100 (cnt 23) -> exp_o=0, unf_o=1;
  - exp_i=30, same data -> exp_o=7, unf_o=0.
